// File: rtl/sram_fc_pkg.sv
// Shared types and default sizes for the SRAM fill/check sequencer.
package sram_fc_pkg;

    localparam int unsigned DW_DEF  = 32;
    localparam int unsigned AW_DEF  = 14;
    localparam int unsigned ECW_DEF = 16;

    typedef enum logic [1:0] {
        MODE_FILL       = 2'd0,
        MODE_CHECK      = 2'd1,
        MODE_FILL_CHECK = 2'd2
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_CHECK = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FIN   = 3'd4
    } state_e;

    // The reserved encoding behaves as FILL_CHECK.
    function automatic mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'd0:    return MODE_FILL;
            2'd1:    return MODE_CHECK;
            default: return MODE_FILL_CHECK;
        endcase
    endfunction

endpackage

// File: rtl/sram_fc_checker.sv
// Read-data checker: one-stage read pipeline, comparator, saturating
// mismatch counter and first-mismatch address capture.
module sram_fc_checker #(
    parameter int unsigned DW  = 32,
    parameter int unsigned AW  = 14,
    parameter int unsigned ECW = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clear_i,
    input  logic           rd_valid_i,
    input  logic [AW-1:0]  rd_addr_i,
    input  logic [DW-1:0]  rd_exp_i,
    input  logic [DW-1:0]  rdata_i,
    output logic           err_o,
    output logic [ECW-1:0] err_cnt_o,
    output logic [AW-1:0]  first_err_addr_o
);

    logic           vld_q;
    logic [AW-1:0]  addr_q;
    logic [DW-1:0]  exp_q;
    logic           err_q, err_d;
    logic [ECW-1:0] cnt_q, cnt_d;
    logic [AW-1:0]  first_q, first_d;
    logic           mismatch;

    // rdata_i belongs to the read registered in the previous cycle.
    assign mismatch = vld_q && (rdata_i != exp_q);

    always_comb begin
        err_d   = err_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        if (clear_i) begin
            err_d   = 1'b0;
            cnt_d   = '0;
            first_d = '0;
        end else if (mismatch) begin
            err_d = 1'b1;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + ECW'(1);
            end
            if (!err_q) begin
                first_d = addr_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q   <= 1'b0;
            addr_q  <= '0;
            exp_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            first_q <= '0;
        end else begin
            vld_q   <= rd_valid_i && !clear_i;
            addr_q  <= rd_addr_i;
            exp_q   <= rd_exp_i;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
        end
    end

    assign err_o            = err_q;
    assign err_cnt_o        = cnt_q;
    assign first_err_addr_o = first_q;

endmodule

// File: rtl/sram_fill_check_ctrl.sv
// Initiator-side sequencer that fills an SRAM address range with a pattern,
// reads it back and compares, or does both back to back.
module sram_fill_check_ctrl
    import sram_fc_pkg::*;
#(
    parameter int unsigned DW  = DW_DEF,
    parameter int unsigned AW  = AW_DEF,
    parameter int unsigned ECW = ECW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [1:0]      mode_i,
    input  logic [AW-1:0]   base_addr_i,
    input  logic [AW:0]     num_words_i,
    input  logic [DW-1:0]   pattern_i,
    input  logic            incr_i,
    input  logic            abort_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            aborted_o,
    output logic            err_o,
    output logic [ECW-1:0]  err_cnt_o,
    output logic [AW-1:0]   first_err_addr_o,
    output logic            en_o,
    output logic [AW-1:0]   addr_o,
    output logic [DW-1:0]   wdata_o,
    output logic            we_o,
    output logic [DW/8-1:0] be_o,
    input  logic [DW-1:0]   rdata_i
);

    state_e        state_q, state_d;
    mode_e         mode_q, mode_d;
    logic [AW:0]   idx_q, idx_d;
    logic [AW:0]   num_q, num_d;
    logic [AW-1:0] base_q, base_d;
    logic [DW-1:0] pat_q, pat_d;
    logic          incr_q, incr_d;
    logic          aborted_q, aborted_d;
    logic          clear;
    logic          rd_issue;
    logic          last;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] exp_word;

    assign last     = (idx_q + (AW+1)'(1)) == num_q;
    assign acc_addr = base_q + idx_q[AW-1:0];
    assign exp_word = pat_q + (incr_q ? DW'(idx_q) : '0);

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        idx_d     = idx_q;
        num_d     = num_q;
        base_d    = base_q;
        pat_d     = pat_q;
        incr_d    = incr_q;
        aborted_d = aborted_q;
        clear     = 1'b0;
        rd_issue  = 1'b0;
        en_o      = 1'b0;
        we_o      = 1'b0;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    clear     = 1'b1;
                    mode_d    = decode_mode(mode_i);
                    idx_d     = '0;
                    num_d     = num_words_i;
                    base_d    = base_addr_i;
                    pat_d     = pattern_i;
                    incr_d    = incr_i;
                    aborted_d = 1'b0;
                    if (num_words_i == '0) begin
                        state_d = ST_FIN;
                    end else if (decode_mode(mode_i) == MODE_CHECK) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                busy_o = 1'b1;
                if (abort_i) begin
                    aborted_d = 1'b1;
                    state_d   = ST_FIN;
                end else begin
                    en_o  = 1'b1;
                    we_o  = 1'b1;
                    idx_d = idx_q + (AW+1)'(1);
                    if (last) begin
                        if (mode_q == MODE_FILL) begin
                            state_d = ST_FIN;
                        end else begin
                            idx_d   = '0;
                            state_d = ST_CHECK;
                        end
                    end
                end
            end
            ST_CHECK: begin
                busy_o = 1'b1;
                // An abort still needs DRAIN so the read already in flight is compared.
                if (abort_i) begin
                    aborted_d = 1'b1;
                    state_d   = ST_DRAIN;
                end else begin
                    en_o     = 1'b1;
                    rd_issue = 1'b1;
                    idx_d    = idx_q + (AW+1)'(1);
                    if (last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                busy_o  = 1'b1;
                state_d = ST_FIN;
            end
            ST_FIN: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_FILL;
            idx_q     <= '0;
            num_q     <= '0;
            base_q    <= '0;
            pat_q     <= '0;
            incr_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            idx_q     <= idx_d;
            num_q     <= num_d;
            base_q    <= base_d;
            pat_q     <= pat_d;
            incr_q    <= incr_d;
            aborted_q <= aborted_d;
        end
    end

    assign addr_o    = en_o ? acc_addr : '0;
    assign wdata_o   = we_o ? exp_word : '0;
    assign be_o      = we_o ? '1 : '0;
    assign aborted_o = aborted_q;

    sram_fc_checker #(
        .DW  (DW),
        .AW  (AW),
        .ECW (ECW)
    ) u_checker (
        .clk              (clk),
        .rst_n            (rst_n),
        .clear_i          (clear),
        .rd_valid_i       (rd_issue),
        .rd_addr_i        (acc_addr),
        .rd_exp_i         (exp_word),
        .rdata_i          (rdata_i),
        .err_o            (err_o),
        .err_cnt_o        (err_cnt_o),
        .first_err_addr_o (first_err_addr_o)
    );

endmodule

// File: tb/tb_sram_fill_check_ctrl.sv
// Bench for sram_fill_check_ctrl: SRAM model, per-operation reference
// timeline built from the access list, and a per-cycle compare process.
module tb_sram_fill_check_ctrl;

    localparam int DEPTH = 16384;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [1:0]  mode_i;
    logic [13:0] base_addr_i;
    logic [14:0] num_words_i;
    logic [31:0] pattern_i;
    logic        incr_i;
    logic        abort_i;
    logic        busy_o, done_o, aborted_o, err_o;
    logic [3:0]  err_cnt_o;
    logic [13:0] first_err_addr_o;
    logic        en_o, we_o;
    logic [13:0] addr_o;
    logic [31:0] wdata_o;
    logic [3:0]  be_o;
    logic [31:0] rdata_i;

    sram_fill_check_ctrl #(.DW(32), .AW(14), .ECW(4)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .mode_i(mode_i),
        .base_addr_i(base_addr_i), .num_words_i(num_words_i), .pattern_i(pattern_i),
        .incr_i(incr_i), .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o),
        .aborted_o(aborted_o), .err_o(err_o), .err_cnt_o(err_cnt_o),
        .first_err_addr_o(first_err_addr_o), .en_o(en_o), .addr_o(addr_o),
        .wdata_o(wdata_o), .we_o(we_o), .be_o(be_o), .rdata_i(rdata_i)
    );

    always #5 clk = ~clk;

    // SRAM bank model; one cycle read latency.
    logic [31:0] mem    [DEPTH];
    logic [31:0] shadow [DEPTH];
    always @(posedge clk) begin
        if (en_o) begin
            if (we_o) begin
                for (int b = 0; b < 4; b++)
                    if (be_o[b]) mem[addr_o][8*b +: 8] = wdata_o[8*b +: 8];
            end else begin
                rdata_i <= mem[addr_o];
            end
        end
    end

    typedef struct packed {
        logic        en;
        logic        we;
        logic [13:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        busy;
        logic        done;
        logic        aborted;
        logic        err;
        logic [3:0]  cnt;
        logic [13:0] first;
    } rec_t;

    rec_t expq[$];
    rec_t hold = '0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        rec_t r;
        if (chk_en) begin
            if (expq.size() > 0) begin
                r = expq.pop_front();
                hold = r;
            end else begin
                r = '0;
                r.aborted = hold.aborted;
                r.err     = hold.err;
                r.cnt     = hold.cnt;
                r.first   = hold.first;
            end
            check("bus", 64'({en_o, we_o, addr_o, wdata_o, be_o}),
                  64'({r.en, r.we, r.addr, r.wdata, r.be}));
            check("ctl", 64'({busy_o, done_o, aborted_o}), 64'({r.busy, r.done, r.aborted}));
            check("status", 64'({err_o, err_cnt_o, first_err_addr_o}),
                  64'({r.err, r.cnt, r.first}));
        end
    end

    function automatic logic [31:0] expv(input logic [31:0] p, input bit inc, input int i);
        return inc ? p + 32'(i) : p;
    endfunction

    function automatic logic [13:0] adr(input int b, input int i);
        return 14'(b + i);
    endfunction

    // Builds the expected per-cycle timeline of one operation, then drives it.
    task automatic run_op(input int mode, input int base, input int n, input logic [31:0] pat,
                          input bit incr, input int abort_at, input int rst_at, output int L);
        bit   wr, rd, ab, errf;
        int   acc_idx[$];
        bit   acc_we[$];
        int   num, issued, j;
        logic [3:0]  cnt;
        logic [13:0] first;
        rec_t recs[$];
        rec_t r;
        wr = (mode != 1);
        rd = (mode != 0);
        if (n > 0) begin
            if (wr) for (int i = 0; i < n; i++) begin acc_we.push_back(1'b1); acc_idx.push_back(i); end
            if (rd) for (int i = 0; i < n; i++) begin acc_we.push_back(1'b0); acc_idx.push_back(i); end
        end
        num = acc_we.size();
        ab = 1'b0;
        issued = num;
        if (n == 0) L = 1;
        else if (abort_at >= 1 && abort_at <= num) begin
            ab = 1'b1;
            issued = abort_at - 1;
            L = acc_we[abort_at-1] ? abort_at + 1 : abort_at + 2;
        end else L = rd ? num + 2 : num + 1;
        if (rst_at > 0 && rst_at < L && rst_at < issued) issued = rst_at;
        for (int k = 0; k < issued; k++)
            if (acc_we[k]) shadow[adr(base, acc_idx[k])] = expv(pat, incr, acc_idx[k]);
        errf = 1'b0; cnt = '0; first = '0;
        for (int o = 1; o <= L; o++) begin
            r = '0;
            j = o - 1;
            if (j < issued) begin
                r.en = 1'b1;
                r.we = acc_we[j];
                r.addr = adr(base, acc_idx[j]);
                r.wdata = acc_we[j] ? expv(pat, incr, acc_idx[j]) : 32'h0;
                r.be = acc_we[j] ? 4'hF : 4'h0;
            end
            // A read issued at offset o-2 is compared at o-1 and visible at o.
            if (o >= 3 && (o - 3) < issued && !acc_we[o-3]) begin
                if (shadow[adr(base, acc_idx[o-3])] != expv(pat, incr, acc_idx[o-3])) begin
                    if (!errf) first = adr(base, acc_idx[o-3]);
                    errf = 1'b1;
                    if (cnt != 4'hF) cnt = cnt + 4'd1;
                end
            end
            r.busy = (o < L);
            r.done = (o == L);
            r.aborted = ab && (o > abort_at);
            r.err = errf; r.cnt = cnt; r.first = first;
            recs.push_back(r);
        end
        if (rst_at > 0 && rst_at < L) begin
            while (recs.size() > rst_at) void'(recs.pop_back());
            recs.push_back('0);
            L = rst_at + 1;
        end

        @(posedge clk); #1;
        start_i = 1'b1; mode_i = 2'(mode); base_addr_i = 14'(base);
        num_words_i = 15'(n); pattern_i = pat; incr_i = incr;
        abort_i = 1'($urandom_range(0, 1));
        @(posedge clk);
        foreach (recs[k]) expq.push_back(recs[k]);
        for (int o = 1; o <= L; o++) begin
            #1;
            start_i = (o < L) ? 1'($urandom_range(0, 1)) : 1'b0;
            mode_i = 2'($urandom); base_addr_i = 14'($urandom);
            num_words_i = 15'($urandom_range(0, 40)); pattern_i = $urandom; incr_i = 1'($urandom);
            abort_i = (o == abort_at);
            rst_n = !(rst_at > 0 && o == rst_at);
            @(posedge clk);
        end
        #1;
        start_i = 1'b0; abort_i = 1'b0; rst_n = 1'b1;
    endtask

    task automatic idle_gap(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk); #1;
            abort_i = 1'($urandom_range(0, 1));
        end
        #1 abort_i = 1'b0;
    endtask

    task automatic corrupt(input int a, input logic [31:0] flip);
        mem[a] = mem[a] ^ flip;
        shadow[a] = shadow[a] ^ flip;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int L, mode, n, ab, na;
        logic [31:0] v;
        for (int i = 0; i < DEPTH; i++) begin
            v = $urandom;
            mem[i] = v;
            shadow[i] = v;
        end
        rdata_i = '0;
        rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; mode_i = '0;
        base_addr_i = '0; num_words_i = '0; pattern_i = '0; incr_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;
        idle_gap(2);

        run_op(0, 'h10, 4, 32'hA5A5A5A5, 1'b0, 0, 0, L);
        check("fill_latency", 64'(L), 64'd5);
        check("fill_mem", 64'({mem[16'h10], mem[16'h13]}), 64'h A5A5A5A5_A5A5A5A5);
        idle_gap(2);

        run_op(2, 'h3FFE, 4, 32'h100, 1'b1, 0, 0, L);
        check("fc_latency", 64'(L), 64'd10);
        check("fc_wrap_mem", 64'({mem[16'h3FFE], mem[16'h0001]}), 64'h00000100_00000103);
        check("fc_no_err", 64'({err_o, err_cnt_o}), 64'h0);
        idle_gap(2);

        run_op(0, 'h20, 8, 32'h55000000, 1'b1, 0, 0, L);
        corrupt('h22, 32'h1);
        run_op(1, 'h20, 8, 32'h55000000, 1'b1, 0, 0, L);
        check("chk_result", 64'({err_o, err_cnt_o, first_err_addr_o}), 64'({1'b1, 4'd1, 14'h22}));
        idle_gap(2);

        run_op(0, 'h40, 0, 32'h0, 1'b0, 0, 0, L);
        check("zero_latency", 64'(L), 64'd1);
        idle_gap(2);

        run_op(1, 'h20, 8, 32'h55000000, 1'b1, 4, 0, L);
        check("abort_result", 64'({aborted_o, err_o, err_cnt_o, first_err_addr_o}),
              64'({1'b1, 1'b1, 4'd1, 14'h22}));
        idle_gap(2);

        run_op(0, 'h100, 20, 32'h0, 1'b0, 0, 0, L);
        for (int i = 0; i < 20; i++) corrupt('h100 + i, 32'h80000000);
        run_op(3, 'h100, 20, 32'h0, 1'b0, 0, 0, L);
        check("fc_refill_clean", 64'(err_cnt_o), 64'd0);
        for (int i = 0; i < 20; i++) corrupt('h100 + i, 32'h80000000);
        run_op(1, 'h100, 20, 32'h0, 1'b0, 0, 0, L);
        check("err_saturate", 64'({err_o, err_cnt_o, first_err_addr_o}), 64'({1'b1, 4'd15, 14'h100}));
        idle_gap(2);

        run_op(0, 'h200, 10, 32'hDEAD0000, 1'b1, 0, 3, L);
        check("reset_outputs", 64'({busy_o, done_o, err_o, en_o}), 64'h0);
        idle_gap(2);

        for (int t = 0; t < 30; t++) begin
            mode = $urandom_range(0, 3);
            n = $urandom_range(0, 40);
            na = (n == 0) ? 0 : ((mode == 2 || mode == 3) ? 2 * n : n);
            ab = ($urandom_range(0, 3) == 0 && na > 0) ? $urandom_range(1, na) : 0;
            if ($urandom_range(0, 1) == 1) corrupt($urandom_range(0, DEPTH - 1), $urandom | 32'h1);
            run_op(mode, $urandom_range(0, DEPTH - 1), n, $urandom, 1'($urandom), ab, 0, L);
            idle_gap($urandom_range(1, 3));
        end

        run_op(0, 'h1234, DEPTH, 32'hC0DE0000, 1'b1, 0, 0, L);
        check("bank_first", 64'(mem[16'h1234]), 64'h C0DE0000);
        check("bank_last", 64'(mem[16'h1233]), 64'(32'hC0DE0000 + 32'd16383));
        idle_gap(2);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_fill_check_ctrl.md
Name: sram_fill_check_ctrl

Overview:
Initiator-side sequencer for the single-port SRAM bank wrappers: drives the en/addr/wdata/we/be/rdata port to fill an address range with a data pattern, read it back and compare, or both in sequence. Sits beside each SRAM bank behind a mux in the memory subsystem and is used for post-reset memory init and built-in test. Software or a test controller issues a start with a range and a pattern, then reads status and error results.

Parameters:
DW, 32, SRAM data width (multiple of 8)
AW, 14, SRAM word-address width
ECW, 16, error-counter width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start_i  in  1  start pulse; sampled only in IDLE
mode_i  in  2  0=FILL, 1=CHECK, 2=FILL_CHECK, 3=reserved (treated as FILL_CHECK)
base_addr_i  in  AW  first word address
num_words_i  in  AW+1  word count, 0..2^AW
pattern_i  in  DW  seed pattern
incr_i  in  1  1: expected word = pattern + index; 0: constant pattern
abort_i  in  1  stop issuing accesses
busy_o  out  1  operation in progress
done_o  out  1  one-cycle completion pulse
aborted_o  out  1  last operation was aborted (held until next start)
err_o  out  1  at least one mismatch in last operation (held)
err_cnt_o  out  ECW  mismatch count, saturating
first_err_addr_o  out  AW  address of first mismatch
en_o  out  1  SRAM enable, active high
addr_o  out  AW  SRAM word address
wdata_o  out  DW  SRAM write data
we_o  out  1  SRAM write enable, active high
be_o  out  DW/8  byte enables, all ones during writes, zero otherwise
rdata_i  in  DW  SRAM read data, valid the cycle after a read

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset: all outputs 0, FSM in IDLE. Reset mid-operation terminates immediately with no done_o pulse. SRAM contents are left as they are.
- FSM states: IDLE, FILL, CHECK, DRAIN, FIN.
- IDLE + start_i: capture base, count, pattern, incr and mode; clear err/err_cnt/first_err_addr/aborted; set index=0; busy_o=1 next cycle. Next state is FILL (mode 0/2/3) or CHECK (mode 1). If num_words_i=0, next state is FIN and no SRAM access occurs.
- FILL: one write per cycle; en_o=1, we_o=1, be_o all ones, addr_o=(base+index) mod 2^AW, wdata_o=expected(index). After index=N-1 the FSM goes to FIN (mode 0) or resets index and goes to CHECK (mode 2). There is no idle cycle between the last write and the first read.
- CHECK: one read per cycle; en_o=1, we_o=0. A one-stage pipeline registers {valid, addr, expected}. Compare rdata_i in the following cycle. After the last read, go to DRAIN (one cycle, last compare, en_o=0), then FIN.
- FIN: done_o=1 and busy_o=0 in this cycle; return to IDLE next cycle.
- Latency: start at cycle t gives first en_o at t+1. FILL_CHECK with N words gives done_o at t+2N+2.
- expected(i) = incr ? (pattern + i) mod 2^DW : pattern.
- Address wrap: base+index wraps modulo 2^AW. num_words=2^AW covers the whole bank exactly once.
- Mismatch: err_o is set and err_cnt_o increments, saturating at 2^ECW-1. first_err_addr_o is written only on the first mismatch.
- abort_i in FILL or CHECK: no further access is issued from that cycle. Any outstanding read is still compared in DRAIN. aborted_o=1 and done_o is pulsed. abort_i in IDLE is ignored.
- start_i while busy is ignored. Simultaneous start_i and abort_i in IDLE: start wins.
- en_o=0 whenever not in FILL or CHECK. wdata_o=0 when we_o=0.

Decomposition:
- Package sram_fc_pkg holds: mode_e enum (FILL, CHECK, FILL_CHECK), state_e enum, and default DW/AW/ECW constants.
- Sub-module sram_fc_checker holds the read pipeline register, the comparator, the saturating error counter and the first-error capture. It has a clear input driven on start.

Test Plan:
- FILL, base=0x10, N=4, pattern=0xA5A5A5A5, incr=0 -> 4 consecutive writes to 0x10..0x13, be_o=0xF, done_o at t+5, err_o=0.
- FILL_CHECK, base=0x3FFE, N=4, pattern=0x100, incr=1 -> writes to 0x3FFE,0x3FFF,0x0000,0x0001 with data 0x100..0x103, reads back with no mismatches, done_o at t+10.
- CHECK over preloaded memory with the word at 0x22 corrupted, base=0x20, N=8 -> err_o=1, err_cnt_o=1, first_err_addr_o=0x22.
- num_words_i=0 -> no en_o at all, done_o at t+1, busy_o never asserted.
- abort_i during CHECK at index 3 -> the read of index 3 is not issued, the read of index 2 is compared, aborted_o=1, done_o pulses.
- ECW=4 and 20 mismatching words -> err_cnt_o saturates at 15. A start while busy has no effect. rst_n low mid-FILL -> en_o=0 in the next cycle and no done_o.
